// File: rtl/rv32_alu.sv
// rv32_alu: registered integer ALU for the RV32I multi-cycle core.
// Operands and function code are captured on the rising clock edge; the result
// and its zero flag are both registered, so they appear exactly one cycle later.
module rv32_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       fn,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int unsigned ShW = $clog2(WIDTH);

  // Function codes: {funct7[5], funct3}
  localparam logic [3:0] FnAdd  = 4'h0;
  localparam logic [3:0] FnSll  = 4'h1;
  localparam logic [3:0] FnSlt  = 4'h2;
  localparam logic [3:0] FnSltu = 4'h3;
  localparam logic [3:0] FnXor  = 4'h4;
  localparam logic [3:0] FnSrl  = 4'h5;
  localparam logic [3:0] FnOr   = 4'h6;
  localparam logic [3:0] FnAnd  = 4'h7;
  localparam logic [3:0] FnSub  = 4'h8;
  localparam logic [3:0] FnSra  = 4'hD;

  logic [ShW-1:0]   sh;
  logic [WIDTH-1:0] res_d;
  logic             lt_signed;
  logic             lt_unsigned;

  // Only the low log2(WIDTH) bits of y select the shift amount.
  assign sh          = y[ShW-1:0];
  assign lt_signed   = $signed(x) < $signed(y);
  assign lt_unsigned = x < y;

  // Combinational result selection; unused codes yield 0.
  always_comb begin
    res_d = '0;
    case (fn)
      FnAdd:   res_d = x + y;
      FnSub:   res_d = x - y;
      FnSll:   res_d = x << sh;
      FnSlt:   res_d = {{(WIDTH-1){1'b0}}, lt_signed};
      FnSltu:  res_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      FnXor:   res_d = x ^ y;
      FnSrl:   res_d = x >> sh;
      FnSra:   res_d = $unsigned($signed(x) >>> sh);
      FnOr:    res_d = x | y;
      FnAnd:   res_d = x & y;
      default: res_d = '0;
    endcase
  end

  // Result and zero flag registered from the same value so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      zero <= 1'b1;
    end else begin
      out  <= res_d;
      zero <= (res_d == '0);
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed and random self-checking bench for rv32_alu.
module tb_rv32_alu;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [3:0]  fn;
  logic [31:0] out;
  logic        zero;

  int checks;
  int failures;

  // Last values the outputs should be holding between edges.
  logic [31:0] last_out;
  logic        last_zero;

  rv32_alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .fn   (fn),
    .out  (out),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: shifts by bit-wise loops, signed compare by sign bits.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    r = 32'h0;
    case (f)
      4'h0: r = a + b;
      4'h8: r = a + ~b + 32'h1;
      4'h1: begin r = a; repeat (s) r = {r[30:0], 1'b0}; end
      4'h5: begin r = a; repeat (s) r = {1'b0, r[31:1]}; end
      4'hD: begin r = a; repeat (s) r = {r[31], r[31:1]}; end
      4'h2: r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, (a < b)};
      4'h3: r = {31'h0, (a < b)};
      4'h4: r = a ^ b;
      4'h6: r = a | b;
      4'h7: r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Called #1 after a rising edge: present operands, confirm outputs hold until
  // the next edge, then confirm the result lands one edge later.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f, input logic [31:0] exp_out);
    x  = a;
    y  = b;
    fn = f;
    #1;
    check({tag, "_hold"}, out, last_out);
    check({tag, "_holdz"}, {31'h0, zero}, {31'h0, last_zero});
    @(posedge clk);
    #1;
    check(tag, out, exp_out);
    check({tag, "_z"}, {31'h0, zero}, {31'h0, (exp_out == 32'h0)});
    last_out  = exp_out;
    last_zero = (exp_out == 32'h0);
  endtask

  logic [3:0] unused_fn [6];
  logic [3:0] rand_fn   [10];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rf;
    checks    = 0;
    failures  = 0;
    unused_fn = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
    rand_fn   = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
    rst = 1'b1;
    x   = 32'h0;
    y   = 32'h0;
    fn  = 4'h0;
    #1;
    check("rst_out", out, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_out  = 32'h0;
    last_zero = 1'b1;

    do_op("add_5_7", 32'd5, 32'd7, 4'h0, 32'd12);

    // Wrap and subtract
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0);
    do_op("sub_3_5", 32'd3, 32'd5, 4'h8, 32'hFFFF_FFFE);
    do_op("sub_eq", 32'h1234, 32'h1234, 4'h8, 32'h0);

    // Shifts
    do_op("sll_4", 32'h8000_0001, 32'd4, 4'h1, 32'h0000_0010);
    do_op("srl_4", 32'h8000_0001, 32'd4, 4'h5, 32'h0800_0000);
    do_op("sra_4", 32'h8000_0001, 32'd4, 4'hD, 32'hF800_0000);
    do_op("sra_24", 32'h8000_0001, 32'h24, 4'hD, 32'hF800_0000);
    do_op("sll_0", 32'h8000_0001, 32'd0, 4'h1, 32'h8000_0001);
    do_op("srl_0", 32'h8000_0001, 32'd0, 4'h5, 32'h8000_0001);
    do_op("sra_0", 32'h8000_0001, 32'd0, 4'hD, 32'h8000_0001);
    do_op("sll_31", 32'h8000_0001, 32'd31, 4'h1, 32'h8000_0000);
    do_op("srl_31", 32'h8000_0001, 32'd31, 4'h5, 32'h0000_0001);
    do_op("sra_31", 32'h8000_0001, 32'd31, 4'hD, 32'hFFFF_FFFF);

    // Compares
    do_op("slt_mn", 32'h8000_0000, 32'h7FFF_FFFF, 4'h2, 32'h1);
    do_op("sltu_mn", 32'h8000_0000, 32'h7FFF_FFFF, 4'h3, 32'h0);
    do_op("slt_sw", 32'h7FFF_FFFF, 32'h8000_0000, 4'h2, 32'h0);
    do_op("sltu_sw", 32'h7FFF_FFFF, 32'h8000_0000, 4'h3, 32'h1);
    do_op("slt_eq", 32'h8000_0000, 32'h8000_0000, 4'h2, 32'h0);
    do_op("sltu_eq", 32'h8000_0000, 32'h8000_0000, 4'h3, 32'h0);

    // Logic
    do_op("xor", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h4, 32'hFF00_0FF0);
    do_op("or", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h6, 32'hFFF0_0FFF);
    do_op("and", 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h7, 32'h00F0_000F);

    // Unused codes
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("unused_%h", unused_fn[i]), 32'hFFFF_FFFF, 32'hFFFF_FFFF, unused_fn[i],
            32'h0);
    end

    // Mid-stream reset between edges, with an operation in flight
    do_op("pre_rst", 32'd100, 32'd23, 4'h0, 32'd123);
    x  = 32'd1;
    y  = 32'd2;
    fn = 4'h0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out", out, 32'h0);
    check("midrst_zero", {31'h0, zero}, 32'h1);
    @(posedge clk);
    #1;
    check("rst_hold_out", out, 32'h0);
    rst       = 1'b0;
    last_out  = 32'h0;
    last_zero = 1'b1;

    // Random back-to-back against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      rf = rand_fn[$urandom_range(9, 0)];
      do_op($sformatf("rand%0d_fn%h", i, rf), ra, rb, rf, ref_alu(ra, rb, rf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Integer ALU for the RV32I multi-cycle core.
- Computes the arithmetic, logic, shift and compare operations used by register-register, register-immediate, load/store address and branch instructions.
- Operands and function code are sampled on the clock edge; the result and zero flag come from registers.
- The core's state machine reads `out` and `zero` one cycle after it presents operands.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two and at least 8.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- x  input  WIDTH  operand 1 (rs1 value)
- y  input  WIDTH  operand 2 (rs2 value or sign-extended immediate)
- fn  input  4  function select, {funct7[5], funct3}
- out  output  WIDTH  registered result
- zero  output  1  registered flag, 1 when the result equals 0

Behaviour:
- Reset: while rst=1, out=0 and zero=1 immediately, independent of clk. Outputs hold these values until the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle, no stall, no handshake. On every rising edge with rst=0, `out` takes f(x, y, fn) from the values present before that edge, and `zero` takes (f(x, y, fn) == 0).
- Back-to-back operations are allowed every cycle.
- zero is computed from the same result that is registered into out, so the two are always consistent.
- Function encoding (SH = y[log2(WIDTH)-1:0], upper y bits ignored for shifts):
  - 0x0 ADD: x + y, modulo 2^WIDTH, carry discarded.
  - 0x8 SUB: x - y, modulo 2^WIDTH. Used for BEQ/BNE through zero.
  - 0x1 SLL: x << SH, zero fill.
  - 0x2 SLT: 1 if signed(x) < signed(y), else 0. Result is zero-extended.
  - 0x3 SLTU: 1 if unsigned(x) < unsigned(y), else 0.
  - 0x4 XOR: x ^ y.
  - 0x5 SRL: x >> SH, zero fill.
  - 0xD SRA: x >> SH, arithmetic, sign bit x[WIDTH-1] replicated.
  - 0x6 OR: x | y.
  - 0x7 AND: x & y.
  - 0x9, 0xA, 0xB, 0xC, 0xE, 0xF: result 0, so zero=1.
- Branch use: BLT/BGE use fn=0x2 and BLTU/BGEU use fn=0x3, with the core testing out != 0. BEQ/BNE use fn=0x8 with zero.
- Boundary conditions:
  - SH=0 returns x unchanged for SLL, SRL and SRA.
  - SH=WIDTH-1 is fully supported.
  - SLT(0x80000000, 0x7FFFFFFF) = 1.
  - SLTU of the same operands = 0.
  - SLT/SLTU with x==y = 0.
  - ADD overflow wraps: 0xFFFFFFFF + 1 = 0, zero=1.
- Reset asserted mid-stream clears the outputs at once. The operation in flight is discarded.

Test Plan:
- Reset: assert rst asynchronously between edges -> out=0 and zero=1 without waiting for a clock. Deassert, apply x=5, y=7, fn=0x0 -> one edge later out=12, zero=0.
- Add/sub wrap: x=0xFFFFFFFF, y=1, fn=0x0 -> out=0, zero=1. Next cycle x=3, y=5, fn=0x8 -> out=0xFFFFFFFE, zero=0. Next cycle x=y=0x1234, fn=0x8 -> zero=1. Check each result lands exactly 1 cycle after its operands.
- Shifts, using x=0x80000001:
  - fn=0x1, y=4 -> out=0x00000010.
  - fn=0x5, y=4 -> out=0x08000000.
  - fn=0xD, y=4 -> out=0xF8000000.
  - fn=0xD, y=0x24 (SH=4, upper bits ignored) -> out=0xF8000000.
  - fn=0x1, y=0 -> out=0x80000001.
- Compares, using x=0x80000000, y=0x7FFFFFFF:
  - fn=0x2 -> out=1.
  - fn=0x3 -> out=0.
  - swapped operands -> SLT out=0, SLTU out=1.
  - x=y, either compare -> out=0, zero=1.
- Logic, using x=0xF0F0_00FF, y=0x0FF0_0F0F:
  - fn=0x4 (XOR) -> out=0xFF000FF0.
  - fn=0x6 (OR) -> out=0xFFF00FFF.
  - fn=0x7 (AND) -> out=0x00F0000F.
- Unused codes: fn=0x9, 0xA, 0xB, 0xC, 0xE, 0xF with x=y=0xFFFFFFFF -> out=0, zero=1 for each. Random back-to-back ops every cycle must match a reference model delayed by 1 cycle.
